// File: rtl/mont_pkg.sv
// Shared types and sizing helpers for the bit-serial Montgomery multiplier.
package mont_pkg;

  localparam int unsigned MONT_WIDTH_DEFAULT = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FINAL = 2'd2
  } state_e;

  // Iteration counter width; it only has to reach WIDTH-1.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/mont_mul_seq_step.sv
// One radix-2 Montgomery iteration: A' = (A + x_i*Y + q*M) / 2 with q chosen to make the sum even.
module mont_step
  import mont_pkg::*;
#(
  parameter int unsigned WIDTH = MONT_WIDTH_DEFAULT
) (
  input  logic [WIDTH+1:0] i_a,
  input  logic             i_x,
  input  logic [WIDTH-1:0] i_y,
  input  logic [WIDTH-1:0] i_m,
  output logic [WIDTH+1:0] o_a_next_c
);

  localparam int unsigned AW = WIDTH + 2;

  logic [AW-1:0] w_t;
  logic [AW-1:0] w_u;

  // With A < 2M the sum stays below 4M, so AW bits never overflow.
  always_comb begin
    w_t        = i_a + (i_x ? AW'(i_y) : '0);
    w_u        = w_t + (w_t[0] ? AW'(i_m) : '0);
    o_a_next_c = w_u >> 1;
  end

endmodule

// File: rtl/mont_mul_seq.sv
// Bit-serial Montgomery multiplier S = X*Y*2^-WIDTH mod M with start/busy/done handshake
// and illegal-operand flagging.
module mont_mul_seq
  import mont_pkg::*;
#(
  parameter int unsigned WIDTH = MONT_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic [WIDTH-1:0] M,
  output logic [WIDTH-1:0] S,
  output logic             done,
  output logic             busy,
  output logic             err
);

  localparam int unsigned AW = WIDTH + 2;
  localparam int unsigned CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  state_e          r_state;
  state_e          w_state_nxt;

  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_m;
  logic [AW-1:0]    r_a;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_s;
  logic             r_done;
  logic             r_busy;
  logic             r_err;

  logic [WIDTH-1:0] w_x_nxt;
  logic [WIDTH-1:0] w_y_nxt;
  logic [WIDTH-1:0] w_m_nxt;
  logic [AW-1:0]    w_a_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [WIDTH-1:0] w_s_nxt;
  logic             w_done_nxt;
  logic             w_busy_nxt;
  logic             w_err_nxt;

  logic             w_ops_bad;
  logic [AW-1:0]    w_a_step;
  logic [AW-1:0]    w_a_sub;
  logic             w_a_ge_m;

  mont_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_a        (r_a),
    .i_x        (r_x[0]),
    .i_y        (r_y),
    .i_m        (r_m),
    .o_a_next_c (w_a_step)
  );

  assign w_ops_bad = ~M[0] | (X >= M) | (Y >= M);
  assign w_a_ge_m  = (r_a >= AW'(r_m));
  assign w_a_sub   = r_a - AW'(r_m);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus next values of every datapath and output register.
  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_m_nxt     = r_m;
    w_a_nxt     = r_a;
    w_cnt_nxt   = r_cnt;
    w_s_nxt     = r_s;
    w_err_nxt   = r_err;
    w_done_nxt  = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_x_nxt = X;
          w_y_nxt = Y;
          w_m_nxt = M;
          if (w_ops_bad) begin
            w_s_nxt    = '0;
            w_err_nxt  = 1'b1;
            w_done_nxt = 1'b1;
          end else begin
            w_a_nxt     = '0;
            w_cnt_nxt   = '0;
            w_state_nxt = CALC;
          end
        end
      end
      CALC: begin
        // X is consumed LSB first by shifting the latched copy.
        w_x_nxt   = r_x >> 1;
        w_a_nxt   = w_a_step;
        w_cnt_nxt = r_cnt + CW'(1);
        if (r_cnt == LAST_ITER) begin
          w_state_nxt = FINAL;
        end
      end
      FINAL: begin
        w_s_nxt     = w_a_ge_m ? WIDTH'(w_a_sub) : WIDTH'(r_a);
        w_err_nxt   = 1'b0;
        w_done_nxt  = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x    <= '0;
      r_y    <= '0;
      r_m    <= '0;
      r_a    <= '0;
      r_cnt  <= '0;
      r_s    <= '0;
      r_done <= 1'b0;
      r_busy <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_x    <= w_x_nxt;
      r_y    <= w_y_nxt;
      r_m    <= w_m_nxt;
      r_a    <= w_a_nxt;
      r_cnt  <= w_cnt_nxt;
      r_s    <= w_s_nxt;
      r_done <= w_done_nxt;
      r_busy <= w_busy_nxt;
      r_err  <= w_err_nxt;
    end
  end

  assign S    = r_s;
  assign done = r_done;
  assign busy = r_busy;
  assign err  = r_err;

endmodule

// File: tb/tb_mont_mul_seq.sv
// Randomized and directed bench for mont_mul_seq at WIDTH=4 and WIDTH=12.
module tb_mont_mul_seq;

  logic        clk = 1'b0;
  logic        rst;

  logic        start4;
  logic [3:0]  x4, y4, m4, s4;
  logic        done4, busy4, err4;

  logic        start12;
  logic [11:0] x12, y12, m12, s12;
  logic        done12, busy12, err12;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mont_mul_seq #(.WIDTH(4)) u_dut4 (
    .clk   (clk),
    .rst   (rst),
    .start (start4),
    .X     (x4),
    .Y     (y4),
    .M     (m4),
    .S     (s4),
    .done  (done4),
    .busy  (busy4),
    .err   (err4)
  );

  mont_mul_seq #(.WIDTH(12)) u_dut12 (
    .clk   (clk),
    .rst   (rst),
    .start (start12),
    .X     (x12),
    .Y     (y12),
    .M     (m12),
    .S     (s12),
    .done  (done12),
    .busy  (busy12),
    .err   (err12)
  );

  task automatic check(input string tag, input longint unsigned obs, input longint unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // X*Y*2^-w mod m by repeated modular halving.
  function automatic longint unsigned ref_mont(input longint unsigned x, input longint unsigned y,
                                               input longint unsigned m, input int w);
    longint unsigned v;
    v = (x * y) % m;
    for (int i = 0; i < w; i++) v = (v % 2 == 1) ? (v + m) / 2 : v / 2;
    return v;
  endfunction

  task automatic drive(input int w, input logic st, input longint unsigned x,
                       input longint unsigned y, input longint unsigned m);
    if (w == 4) begin
      start4 = st; x4 = 4'(x); y4 = 4'(y); m4 = 4'(m);
    end else begin
      start12 = st; x12 = 12'(x); y12 = 12'(y); m12 = 12'(m);
    end
  endtask

  task automatic set_start(input int w, input logic st);
    if (w == 4) start4 = st;
    else        start12 = st;
  endtask

  function automatic longint unsigned get_s(input int w);
    return (w == 4) ? 64'(s4) : 64'(s12);
  endfunction
  function automatic longint unsigned get_done(input int w);
    return (w == 4) ? 64'(done4) : 64'(done12);
  endfunction
  function automatic longint unsigned get_busy(input int w);
    return (w == 4) ? 64'(busy4) : 64'(busy12);
  endfunction
  function automatic longint unsigned get_err(input int w);
    return (w == 4) ? 64'(err4) : 64'(err12);
  endfunction

  // Issues start in the current cycle (cycle 0); returns after sampling the done cycle.
  task automatic run_op(input int w, input longint unsigned x, input longint unsigned y,
                        input longint unsigned m, input string tag);
    bit              legal;
    int              lat;
    longint unsigned exp_s;
    legal = (m % 2 == 1) && (x < m) && (y < m);
    lat   = legal ? w + 2 : 1;
    exp_s = legal ? ref_mont(x, y, m, w) : 0;
    drive(w, 1'b1, x, y, m);
    for (int c = 1; c <= lat; c++) begin
      @(posedge clk); #1;
      if (c == 1) set_start(w, 1'b0);
      if (c == 2) drive(w, 1'b0, $urandom, $urandom, $urandom);
      @(negedge clk);
      check({tag, " done"}, get_done(w), (c == lat) ? 1 : 0);
      check({tag, " busy"}, get_busy(w), (legal && c <= w + 1) ? 1 : 0);
    end
    check({tag, " S"}, get_s(w), exp_s);
    check({tag, " err"}, get_err(w), legal ? 0 : 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    longint unsigned rm, rx, ry;
    rst = 1'b1;
    drive(4, 1'b0, 0, 0, 1);
    drive(12, 1'b0, 0, 0, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst S4", s4, 0);
    check("rst done4", done4, 0);
    check("rst busy4", busy4, 0);
    check("rst err4", err4, 0);
    check("rst S12", s12, 0);
    check("rst done12", done12, 0);
    check("rst busy12", busy12, 0);
    check("rst err12", err12, 0);

    // Directed cases with hand-derived results.
    @(posedge clk); #1;
    run_op(4, 7, 5, 13, "w4_7x5");
    check("w4_7x5 const", s4, 3);
    @(posedge clk); #1;
    run_op(4, 11, 12, 13, "w4_11x12");
    check("w4_11x12 const", s4, 5);

    @(posedge clk); #1;
    run_op(12, 1, 1, 4093, "w12_1x1");
    check("w12_1x1 const", s12, 2729);
    run_op(12, 3, 1234, 4093, "w12_b2b");
    check("w12_b2b const", s12, 1234);

    @(posedge clk); #1;
    run_op(12, 1, 1, 4092, "even_m");
    run_op(12, 4093, 1, 4093, "x_ge_m");
    run_op(12, 5, 4093, 4093, "y_ge_m");
    run_op(12, 5, 6, 4093, "clr_err");

    // Start re-pulsed and inputs changed mid-operation must be ignored.
    @(posedge clk); #1;
    drive(12, 1'b1, 1, 1, 4093);
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk); #1;
      case (c)
        1, 4, 8: start12 = 1'b0;
        3, 7:    start12 = 1'b1;
        5:       begin x12 = 12'd77; y12 = 12'd99; end
        default: ;
      endcase
      @(negedge clk);
      check("ignore done", done12, (c == 14) ? 1 : 0);
      check("ignore busy", busy12, (c <= 13) ? 1 : 0);
      if (c == 14) check("ignore S", s12, 2729);
    end

    // Reset in the middle of an operation.
    @(posedge clk); #1;
    drive(12, 1'b1, 5, 7, 4093);
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk); #1;
      if (c == 1) start12 = 1'b0;
      if (c == 6) rst = 1'b1;
      if (c == 7) rst = 1'b0;
      @(negedge clk);
      if (c <= 6) begin
        check("abort busy", busy12, 1);
        check("abort done", done12, 0);
      end else begin
        check("abort S", s12, 0);
        check("abort done", done12, 0);
        check("abort busy", busy12, 0);
        check("abort err", err12, 0);
      end
    end
    @(posedge clk); #1;
    run_op(12, 5, 7, 4093, "post_rst");

    // Random operands, a mix of back-to-back and gapped requests, some illegal.
    for (int k = 0; k < 24; k++) begin
      rm = 64'($urandom_range(1, 2047)) * 2 + 1;
      rx = 64'($urandom_range(0, 32'(rm - 1)));
      ry = 64'($urandom_range(0, 32'(rm - 1)));
      if (k % 6 == 5) rm = rm - 1;
      if (k % 7 == 3) rx = rm;
      if (k % 2 == 0) begin
        @(posedge clk); #1;
      end
      run_op(12, rx, ry, rm, "rnd12");
    end
    for (int k = 0; k < 16; k++) begin
      rm = 64'($urandom_range(1, 7)) * 2 + 1;
      rx = 64'($urandom_range(0, 32'(rm - 1)));
      ry = 64'($urandom_range(0, 32'(rm - 1)));
      if (k % 5 == 4) ry = 15;
      run_op(4, rx, ry, rm, "rnd4");
    end

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
